id_issue_ctrl: RTL and testbench

Issue controller for the instruction-decode stage. Sequences transfers from the prefetch unit into the ID pipeline register and from that register into the execute stage. Tracks in-flight register-file writes in a per-register scoreboard so that read-after-write and write-after-write hazards stall decode. Handles flush/vectoring by discarding stale fetches until the start-of-fetch-run marker arrives.

---
 rtl/id_pkg.sv | 26 ++
 rtl/id_scoreboard.sv | 76 +++++++
 rtl/id_issue_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_id_issue_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_pkg.sv
// -----------------------------------------------------------------------------
// id_pkg
// Shared types and constants for the instruction-decode issue controller.
//   t_idc_state : issue controller state (DRAIN, RUN, WAIT_FLUSH)
//   cnt_width() : scoreboard counter width for a given outstanding-write limit
//   ID_ADDR_W   : register address width used by decoder and write-back ports
// -----------------------------------------------------------------------------
package id_pkg;

  typedef enum logic [1:0] {
    DRAIN      = 2'd0,  // discarding stale fetches until start-of-fetch-run
    RUN        = 2'd1,  // normal decode/issue
    WAIT_FLUSH = 2'd2   // error instruction loaded, wait for EX to vector
  } t_idc_state;

  localparam int unsigned ID_ADDR_W       = 5;
  localparam int unsigned ID_MAX_INFLIGHT = 3;

  // A counter must be able to hold 0..max_inflight inclusive.
  function automatic int unsigned cnt_width(input int unsigned max_inflight);
    return $clog2(max_inflight + 1);
  endfunction

  localparam int unsigned ID_CNT_W = cnt_width(ID_MAX_INFLIGHT);

endpackage

// File: rtl/id_scoreboard.sv
// -----------------------------------------------------------------------------
// id_scoreboard
// Per-register count of outstanding register-file writes.
//   clk_i, resetb_i           : clock, asynchronous active-low reset
//   inc_i / inc_addr_i        : one more write in flight for inc_addr_i
//   dec_i / dec_addr_i        : one write retired for dec_addr_i
//   rd1_addr_i / rd1_busy_o   : source 1 has at least one write in flight
//   rd2_addr_i / rd2_busy_o   : source 2 has at least one write in flight
//   full_addr_i / full_o      : destination already at the in-flight limit
// Register 0 and addresses at or above P_NREGS are never tracked and always
// read as idle. Callers gate inc/dec with the clock enable.
// -----------------------------------------------------------------------------
module id_scoreboard
  import id_pkg::*;
#(
  parameter int unsigned P_NREGS        = 32,
  parameter int unsigned P_MAX_INFLIGHT = 3,
  parameter int unsigned P_CNT_W        = cnt_width(P_MAX_INFLIGHT)
) (
  input  logic                 clk_i,
  input  logic                 resetb_i,
  input  logic                 inc_i,
  input  logic [ID_ADDR_W-1:0] inc_addr_i,
  input  logic                 dec_i,
  input  logic [ID_ADDR_W-1:0] dec_addr_i,
  input  logic [ID_ADDR_W-1:0] rd1_addr_i,
  output logic                 rd1_busy_o,
  input  logic [ID_ADDR_W-1:0] rd2_addr_i,
  output logic                 rd2_busy_o,
  input  logic [ID_ADDR_W-1:0] full_addr_i,
  output logic                 full_o
);

  localparam int unsigned          NSLOTS = 2 ** ID_ADDR_W;
  localparam logic [P_CNT_W-1:0]   MAX_C  = P_CNT_W'(P_MAX_INFLIGHT);

  logic [NSLOTS-1:0] busy_vec;
  logic [NSLOTS-1:0] full_vec;

  genvar gi;
  generate
    for (gi = 0; gi < NSLOTS; gi++) begin : g_slot
      if (gi == 0 || gi >= P_NREGS) begin : g_none
        assign busy_vec[gi] = 1'b0;
        assign full_vec[gi] = 1'b0;
      end else begin : g_cnt
        logic [P_CNT_W-1:0] cnt_reg;
        logic               inc_hit;
        logic               dec_hit;

        assign inc_hit = inc_i && (inc_addr_i == ID_ADDR_W'(gi));
        assign dec_hit = dec_i && (dec_addr_i == ID_ADDR_W'(gi));

        // Simultaneous issue and retire of the same register cancel out.
        // A retire with nothing outstanding is ignored rather than wrapping.
        always_ff @(posedge clk_i or negedge resetb_i) begin
          if (!resetb_i) begin
            cnt_reg <= '0;
          end else if (inc_hit && !dec_hit) begin
            cnt_reg <= cnt_reg + P_CNT_W'(1);
          end else if (dec_hit && !inc_hit && (cnt_reg != '0)) begin
            cnt_reg <= cnt_reg - P_CNT_W'(1);
          end
        end

        assign busy_vec[gi] = (cnt_reg != '0);
        assign full_vec[gi] = (cnt_reg == MAX_C);
      end
    end
  endgenerate

  assign rd1_busy_o = busy_vec[rd1_addr_i];
  assign rd2_busy_o = busy_vec[rd2_addr_i];
  assign full_o     = full_vec[full_addr_i];

endmodule

// File: rtl/id_issue_ctrl.sv
// -----------------------------------------------------------------------------
// id_issue_ctrl
// Issue controller for the instruction-decode stage. Moves fetches from the
// prefetch unit into the ID pipeline register and hands them to EX, stalling
// on read-after-write / write-after-write hazards tracked by id_scoreboard.
// After a flush, fetches are discarded until the start-of-fetch-run marker.
//   clk_i, resetb_i, clk_en_i     : clock, async active-low reset, clock enable
//   pfu_dav_i/sofr_i/ferr_i       : fetch valid, first-after-vector, fetch error
//   pfu_pull_o                    : consume the current fetch
//   dec_*                         : decoder view of the offered fetch
//   ids_load_o                    : capture enable for the ID pipeline register
//   ids_dav_o / ids_err_o         : ID register valid / carries an error
//   ids_ack_i                     : EX accepts the held instruction
//   wb_regd_wr_i / wb_regd_addr_i : write-back retire
//   flush_i                       : EX vectoring, kill ID contents
//   stall_o                       : hazard stall this cycle
// -----------------------------------------------------------------------------
module id_issue_ctrl
  import id_pkg::*;
#(
  parameter int unsigned P_NREGS        = 32,
  parameter int unsigned P_MAX_INFLIGHT = 3
) (
  input  logic                 clk_i,
  input  logic                 resetb_i,
  input  logic                 clk_en_i,
  input  logic                 pfu_dav_i,
  input  logic                 pfu_sofr_i,
  input  logic                 pfu_ferr_i,
  output logic                 pfu_pull_o,
  input  logic                 dec_ins_err_i,
  input  logic                 dec_regs1_rd_i,
  input  logic                 dec_regs2_rd_i,
  input  logic [ID_ADDR_W-1:0] dec_regs1_addr_i,
  input  logic [ID_ADDR_W-1:0] dec_regs2_addr_i,
  input  logic                 dec_regd_wr_i,
  input  logic [ID_ADDR_W-1:0] dec_regd_addr_i,
  output logic                 ids_load_o,
  output logic                 ids_dav_o,
  input  logic                 ids_ack_i,
  output logic                 ids_err_o,
  input  logic                 wb_regd_wr_i,
  input  logic [ID_ADDR_W-1:0] wb_regd_addr_i,
  input  logic                 flush_i,
  output logic                 stall_o
);

  localparam int unsigned CNT_W = cnt_width(P_MAX_INFLIGHT);

  t_idc_state           state_reg, state_next;
  logic                 ids_dav_reg, ids_dav_next;
  logic                 ids_err_reg, ids_err_next;
  // Destination of the held instruction, kept for the scoreboard update
  // when EX accepts it.
  logic                 id_regd_wr_reg, id_regd_wr_next;
  logic [ID_ADDR_W-1:0] id_regd_addr_reg, id_regd_addr_next;

  logic rs1_busy, rs2_busy, rd_full;
  logic sb_inc, sb_dec;
  logic issue, space, fetch_err, hazard;
  logic run_mode, load;

  // ---------------------------------------------------------------------------
  // Hazard detection against registered counters only: a retire in this cycle
  // releases the dependent instruction one cycle later.
  // ---------------------------------------------------------------------------
  always_comb begin
    issue     = ids_dav_reg & ids_ack_i & ~flush_i;
    space     = ~ids_dav_reg | issue;
    fetch_err = pfu_ferr_i | dec_ins_err_i;
    // An erroneous instruction never touches the register file, so its
    // operands cannot hazard.
    hazard    = ~fetch_err &
                ((dec_regs1_rd_i & (dec_regs1_addr_i != '0) & rs1_busy) |
                 (dec_regs2_rd_i & (dec_regs2_addr_i != '0) & rs2_busy) |
                 (dec_regd_wr_i  & (dec_regd_addr_i  != '0) & rd_full));
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state_reg        <= DRAIN;
      ids_dav_reg      <= 1'b0;
      ids_err_reg      <= 1'b0;
      id_regd_wr_reg   <= 1'b0;
      id_regd_addr_reg <= '0;
    end else if (clk_en_i) begin
      state_reg        <= state_next;
      ids_dav_reg      <= ids_dav_next;
      ids_err_reg      <= ids_err_next;
      id_regd_wr_reg   <= id_regd_wr_next;
      id_regd_addr_reg <= id_regd_addr_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next        = state_reg;
    ids_dav_next      = ids_dav_reg;
    ids_err_next      = ids_err_reg;
    id_regd_wr_next   = id_regd_wr_reg;
    id_regd_addr_next = id_regd_addr_reg;
    run_mode          = 1'b0;
    ids_load_o        = 1'b0;
    pfu_pull_o        = 1'b0;
    stall_o           = 1'b0;

    case (state_reg)
      DRAIN: begin
        // The start-of-run fetch is decoded normally in the same cycle;
        // anything older is pulled and thrown away.
        run_mode = pfu_sofr_i;
        if (!pfu_sofr_i) begin
          pfu_pull_o = clk_en_i & pfu_dav_i;
        end
      end
      RUN: begin
        run_mode = 1'b1;
      end
      WAIT_FLUSH: begin
        run_mode = 1'b0;
      end
      default: begin
        state_next = DRAIN;
      end
    endcase

    load    = run_mode & space & pfu_dav_i & ~hazard & ~flush_i;
    stall_o = run_mode & pfu_dav_i & space & hazard;

    if (load) begin
      ids_load_o = clk_en_i;
      pfu_pull_o = clk_en_i;
    end

    if (issue) begin
      ids_dav_next = 1'b0;
      ids_err_next = 1'b0;
    end

    if (load) begin
      ids_dav_next      = 1'b1;
      ids_err_next      = fetch_err;
      id_regd_wr_next   = dec_regd_wr_i & ~fetch_err;
      id_regd_addr_next = dec_regd_addr_i;
      state_next        = fetch_err ? WAIT_FLUSH : RUN;
    end

    if (flush_i) begin
      ids_dav_next = 1'b0;
      ids_err_next = 1'b0;
      state_next   = DRAIN;
    end

    // Handshakes stay quiet while reset is held, even though the state
    // register already reads DRAIN.
    if (!resetb_i) begin
      ids_load_o = 1'b0;
      pfu_pull_o = 1'b0;
      stall_o    = 1'b0;
    end
  end

  assign ids_dav_o = ids_dav_reg;
  assign ids_err_o = ids_err_reg;

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  assign sb_inc = clk_en_i & issue & id_regd_wr_reg & (id_regd_addr_reg != '0);
  assign sb_dec = clk_en_i & wb_regd_wr_i & (wb_regd_addr_i != '0);

  id_scoreboard #(
    .P_NREGS        (P_NREGS),
    .P_MAX_INFLIGHT (P_MAX_INFLIGHT),
    .P_CNT_W        (CNT_W)
  ) u_scoreboard (
    .clk_i       (clk_i),
    .resetb_i    (resetb_i),
    .inc_i       (sb_inc),
    .inc_addr_i  (id_regd_addr_reg),
    .dec_i       (sb_dec),
    .dec_addr_i  (wb_regd_addr_i),
    .rd1_addr_i  (dec_regs1_addr_i),
    .rd1_busy_o  (rs1_busy),
    .rd2_addr_i  (dec_regs2_addr_i),
    .rd2_busy_o  (rs2_busy),
    .full_addr_i (dec_regd_addr_i),
    .full_o      (rd_full)
  );

endmodule

// File: tb/tb_id_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_id_issue_ctrl
// Directed scenarios followed by randomized traffic, checked every cycle
// against a behavioural model of the issue controller (mode, ID slot contents,
// per-register outstanding-write counts as plain integers).
// -----------------------------------------------------------------------------
module tb_id_issue_ctrl;

  localparam int NREGS  = 32;
  localparam int MAXF   = 3;
  localparam int M_DRAIN = 0;
  localparam int M_RUN   = 1;
  localparam int M_WAIT  = 2;

  logic       clk_i = 1'b0;
  logic       resetb_i;
  logic       clk_en_i;
  logic       pfu_dav_i, pfu_sofr_i, pfu_ferr_i;
  logic       pfu_pull_o;
  logic       dec_ins_err_i;
  logic       dec_regs1_rd_i, dec_regs2_rd_i;
  logic [4:0] dec_regs1_addr_i, dec_regs2_addr_i;
  logic       dec_regd_wr_i;
  logic [4:0] dec_regd_addr_i;
  logic       ids_load_o, ids_dav_o, ids_ack_i, ids_err_o;
  logic       wb_regd_wr_i;
  logic [4:0] wb_regd_addr_i;
  logic       flush_i;
  logic       stall_o;

  always #5 clk_i = ~clk_i;

  id_issue_ctrl #(
    .P_NREGS        (NREGS),
    .P_MAX_INFLIGHT (MAXF)
  ) dut (
    .clk_i            (clk_i),
    .resetb_i         (resetb_i),
    .clk_en_i         (clk_en_i),
    .pfu_dav_i        (pfu_dav_i),
    .pfu_sofr_i       (pfu_sofr_i),
    .pfu_ferr_i       (pfu_ferr_i),
    .pfu_pull_o       (pfu_pull_o),
    .dec_ins_err_i    (dec_ins_err_i),
    .dec_regs1_rd_i   (dec_regs1_rd_i),
    .dec_regs2_rd_i   (dec_regs2_rd_i),
    .dec_regs1_addr_i (dec_regs1_addr_i),
    .dec_regs2_addr_i (dec_regs2_addr_i),
    .dec_regd_wr_i    (dec_regd_wr_i),
    .dec_regd_addr_i  (dec_regd_addr_i),
    .ids_load_o       (ids_load_o),
    .ids_dav_o        (ids_dav_o),
    .ids_ack_i        (ids_ack_i),
    .ids_err_o        (ids_err_o),
    .wb_regd_wr_i     (wb_regd_wr_i),
    .wb_regd_addr_i   (wb_regd_addr_i),
    .flush_i          (flush_i),
    .stall_o          (stall_o)
  );

  int total = 0;
  int bad   = 0;

  // ---------------- behavioural model ----------------
  int m_mode;
  bit m_valid, m_err, m_wr;
  int m_wd;
  int cnt [NREGS];
  int issued = 0;
  bit e_load, e_pull, e_stall;

  function automatic void model_reset();
    m_mode  = M_DRAIN;
    m_valid = 1'b0;
    m_err   = 1'b0;
    m_wr    = 1'b0;
    m_wd    = 0;
    for (int i = 0; i < NREGS; i++) cnt[i] = 0;
  endfunction

  task automatic check(input string name, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0b exp=%0b", name, $time, got, exp);
    end
  endtask

  // Expected handshake outputs for the current inputs and model state.
  function automatic void model_outputs();
    bit space, err_in, haz, active;
    int a1, a2, ad;
    a1 = int'(dec_regs1_addr_i);
    a2 = int'(dec_regs2_addr_i);
    ad = int'(dec_regd_addr_i);
    space  = !m_valid || (ids_ack_i && !flush_i);
    err_in = pfu_ferr_i || dec_ins_err_i;
    haz    = !err_in && ((dec_regs1_rd_i && a1 != 0 && cnt[a1] > 0) ||
                         (dec_regs2_rd_i && a2 != 0 && cnt[a2] > 0) ||
                         (dec_regd_wr_i  && ad != 0 && cnt[ad] >= MAXF));
    active  = resetb_i && (m_mode == M_RUN || (m_mode == M_DRAIN && pfu_sofr_i));
    e_load  = clk_en_i && active && space && pfu_dav_i && !haz && !flush_i;
    e_pull  = e_load || (resetb_i && clk_en_i && m_mode == M_DRAIN && pfu_dav_i && !pfu_sofr_i);
    e_stall = active && pfu_dav_i && space && haz;
  endfunction

  // State change at a clock edge, using the inputs present at that edge.
  task automatic model_advance();
    bit issue, inc, dec, err_in;
    int ir, dr;
    if (!resetb_i) begin
      model_reset();
      return;
    end
    if (!clk_en_i) return;
    issue = m_valid && ids_ack_i && !flush_i;
    if (issue) begin
      issued++;
      $display("issue %0d: err=%0b wr=%0b rd=x%0d t=%0t", issued, m_err, m_wr, m_wd, $time);
    end
    inc = issue && m_wr && m_wd != 0;
    ir  = m_wd;
    dec = wb_regd_wr_i && wb_regd_addr_i != 5'd0;
    dr  = int'(wb_regd_addr_i);
    if (dec) begin
      total++;
      if (cnt[dr] == 0) begin
        bad++;
        $display("FAIL wb_at_zero t=%0t reg=x%0d got=0 exp>0", $time, dr);
      end
    end
    if (!(inc && dec && ir == dr)) begin
      if (inc) cnt[ir]++;
      if (dec && cnt[dr] > 0) cnt[dr]--;
    end
    if (inc) begin
      total++;
      if (cnt[ir] > MAXF) begin
        bad++;
        $display("FAIL cnt_overflow t=%0t reg=x%0d got=%0d exp<=%0d", $time, ir, cnt[ir], MAXF);
      end
    end
    if (flush_i) begin
      m_mode  = M_DRAIN;
      m_valid = 1'b0;
      m_err   = 1'b0;
    end else begin
      if (issue) begin
        m_valid = 1'b0;
        m_err   = 1'b0;
      end
      if (e_load) begin
        err_in  = pfu_ferr_i || dec_ins_err_i;
        m_valid = 1'b1;
        m_err   = err_in;
        m_wr    = dec_regd_wr_i && !err_in;
        m_wd    = int'(dec_regd_addr_i);
        m_mode  = err_in ? M_WAIT : M_RUN;
      end
    end
  endtask

  // Called at posedge+1 with inputs set; compares mid-cycle, returns at the
  // next posedge+1. Optional literal expectations for load/pull/stall.
  task automatic tick(input int xl = -1, input int xp = -1, input int xs = -1);
    #3;
    if (!resetb_i) model_reset();
    model_outputs();
    check("ids_dav_o",  ids_dav_o,  m_valid);
    check("ids_err_o",  ids_err_o,  m_err);
    check("ids_load_o", ids_load_o, e_load);
    check("pfu_pull_o", pfu_pull_o, e_pull);
    check("stall_o",    stall_o,    e_stall);
    if (xl >= 0) check("lit_load",  ids_load_o, xl != 0);
    if (xp >= 0) check("lit_pull",  pfu_pull_o, xp != 0);
    if (xs >= 0) check("lit_stall", stall_o,    xs != 0);
    @(posedge clk_i);
    model_advance();
    #1;
  endtask

  task automatic idle();
    clk_en_i         = 1'b1;
    pfu_dav_i        = 1'b0;
    pfu_sofr_i       = 1'b0;
    pfu_ferr_i       = 1'b0;
    dec_ins_err_i    = 1'b0;
    dec_regs1_rd_i   = 1'b0;
    dec_regs1_addr_i = 5'd0;
    dec_regs2_rd_i   = 1'b0;
    dec_regs2_addr_i = 5'd0;
    dec_regd_wr_i    = 1'b0;
    dec_regd_addr_i  = 5'd0;
    ids_ack_i        = 1'b0;
    wb_regd_wr_i     = 1'b0;
    wb_regd_addr_i   = 5'd0;
    flush_i          = 1'b0;
  endtask

  task automatic fetch(input bit wr, input int rd, input bit r1, input int s1);
    pfu_dav_i        = 1'b1;
    dec_regd_wr_i    = wr;
    dec_regd_addr_i  = 5'(rd);
    dec_regs1_rd_i   = r1;
    dec_regs1_addr_i = 5'(s1);
  endtask

  task automatic wb(input int r);
    wb_regd_wr_i   = 1'b1;
    wb_regd_addr_i = 5'(r);
  endtask

  task automatic randomize_inputs();
    int r;
    resetb_i         = ($urandom_range(0, 299) != 0);
    clk_en_i         = ($urandom_range(0, 9) != 0);
    pfu_dav_i        = ($urandom_range(0, 9) < 7);
    pfu_sofr_i       = (m_mode == M_DRAIN) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
    pfu_ferr_i       = ($urandom_range(0, 39) == 0);
    dec_ins_err_i    = ($urandom_range(0, 39) == 0);
    dec_regs1_rd_i   = ($urandom_range(0, 1) == 1);
    dec_regs1_addr_i = 5'($urandom_range(0, 7));
    dec_regs2_rd_i   = ($urandom_range(0, 1) == 1);
    dec_regs2_addr_i = 5'($urandom_range(0, 7));
    dec_regd_wr_i    = ($urandom_range(0, 1) == 1);
    dec_regd_addr_i  = 5'($urandom_range(0, 7));
    // A writer may load while the held writer of the same register issues;
    // keep the outstanding total within the limit.
    if (dec_regd_wr_i && m_valid && m_wr && m_wd == int'(dec_regd_addr_i) &&
        m_wd != 0 && cnt[m_wd] >= MAXF - 1)
      dec_regd_wr_i = 1'b0;
    ids_ack_i = ($urandom_range(0, 9) < 6);
    flush_i   = (m_mode == M_WAIT) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 49) == 0);
    r = $urandom_range(1, 7);
    if ($urandom_range(0, 9) < 4 && cnt[r] > 0) begin
      wb_regd_wr_i = 1'b1; wb_regd_addr_i = 5'(r);
    end else if ($urandom_range(0, 29) == 0) begin
      wb_regd_wr_i = 1'b1; wb_regd_addr_i = 5'd0;
    end else begin
      wb_regd_wr_i = 1'b0; wb_regd_addr_i = 5'(r);
    end
  endtask

  initial begin
    idle();
    resetb_i   = 1'b0;
    pfu_dav_i  = 1'b1;
    pfu_sofr_i = 1'b1;
    model_reset();
    @(posedge clk_i);
    #1;
    // reset: handshakes held low even with a sofr fetch offered
    tick(0, 0, 0);
    tick(0, 0, 0);
    check("rst_dav", ids_dav_o, 1'b0);
    check("rst_err", ids_err_o, 1'b0);
    resetb_i = 1'b1;

    // stale fetch dropped, sofr fetch loaded
    idle(); pfu_dav_i = 1'b1;
    tick(0, 1, 0);
    pfu_sofr_i = 1'b1;
    tick(1, 1, 0);
    idle();
    check("sofr_dav", ids_dav_o, 1'b1);
    ids_ack_i = 1'b1;
    tick();

    // RAW on x5
    idle(); fetch(1, 5, 0, 0); tick(1, 1, 0);
    idle(); ids_ack_i = 1'b1; tick();
    idle(); fetch(0, 0, 1, 5); tick(0, 0, 1);
    wb(5); tick(0, 0, 1);
    wb_regd_wr_i = 1'b0; tick(1, 1, 0);
    idle(); ids_ack_i = 1'b1; tick();
    idle(); fetch(0, 0, 1, 5); tick(1, 1, 0);
    idle(); ids_ack_i = 1'b1; tick();

    // WAW full on x7, then same-cycle issue and retire
    idle(); fetch(1, 7, 0, 0); tick(1, 1, 0);
    ids_ack_i = 1'b1; tick(1, 1, 0);
    tick(1, 1, 0);
    idle(); ids_ack_i = 1'b1; tick();
    idle(); fetch(1, 7, 0, 0); tick(0, 0, 1);
    wb(7); tick(0, 0, 1);
    wb_regd_wr_i = 1'b0; tick(1, 1, 0);
    idle(); ids_ack_i = 1'b1; wb(7); tick();
    idle(); fetch(0, 0, 1, 7); wb(7); tick(0, 0, 1);
    tick(0, 0, 1);
    wb_regd_wr_i = 1'b0; tick(1, 1, 0);
    idle(); ids_ack_i = 1'b1; tick();

    // fetch error: load despite hazard rules, then no pulls until flush
    idle(); fetch(1, 9, 0, 0); pfu_ferr_i = 1'b1; tick(1, 1, 0);
    idle();
    check("ferr_err", ids_err_o, 1'b1);
    check("ferr_dav", ids_dav_o, 1'b1);
    fetch(0, 0, 1, 9); ids_ack_i = 1'b1; tick(0, 0, 0);
    idle(); fetch(0, 0, 1, 9); tick(0, 0, 0);
    flush_i = 1'b1; tick(0, 0, 0);
    idle();
    check("flush_err", ids_err_o, 1'b0);
    fetch(0, 0, 1, 9); pfu_sofr_i = 1'b1; tick(1, 1, 0);
    idle(); ids_ack_i = 1'b1; tick();

    // flush coincident with ack of an x3 writer
    idle(); fetch(1, 3, 0, 0); tick(1, 1, 0);
    idle(); ids_ack_i = 1'b1; flush_i = 1'b1; tick();
    idle();
    check("flush_dav", ids_dav_o, 1'b0);
    fetch(0, 0, 1, 3); pfu_sofr_i = 1'b1; tick(1, 1, 0);
    // x0 writers stream back to back and never stall
    idle();
    for (int k = 0; k < 6; k++) begin
      fetch(1, 0, 1, 0); ids_ack_i = 1'b1; tick(1, 1, 0);
    end
    idle(); ids_ack_i = 1'b1; tick();

    // clock enable low freezes everything
    idle(); fetch(1, 4, 0, 0); clk_en_i = 1'b0; tick(0, 0, 0);
    tick(0, 0, 0);
    check("cken_dav0", ids_dav_o, 1'b0);
    clk_en_i = 1'b1; tick(1, 1, 0);
    idle(); clk_en_i = 1'b0; ids_ack_i = 1'b1; tick();
    check("cken_dav1", ids_dav_o, 1'b1);
    idle(); ids_ack_i = 1'b1; tick();
    idle(); fetch(0, 0, 0, 0); tick(1, 1, 0);

    // reset mid-operation: ID contents and x4 count discarded
    idle(); resetb_i = 1'b0; tick(0, 0, 0);
    check("mid_rst_dav", ids_dav_o, 1'b0);
    resetb_i = 1'b1;
    fetch(0, 0, 1, 4); pfu_sofr_i = 1'b1; tick(1, 1, 0);
    idle(); ids_ack_i = 1'b1; tick();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      randomize_inputs();
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
